bias_feeder: RTL

- Read-side producer for the bias stage.
- On `start`, fetches NUM_COLS signed 16-bit bias scalars from the unified buffer (UB) into staging registers, one outstanding read at a time.
- Commits all columns to the bias children in a single cycle, via a per-column load-enable pulse plus a load-new-bias strobe.
- The commit is held off while the systolic array is streaming valid data, so a bias never changes mid-tile.

---
 rtl/bias_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bias_feeder.sv
// Bias fetch sequencer: reads NUM_COLS signed 16-bit scalars from the unified
// buffer one at a time, then commits them to every bias column in one cycle.
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | one-cycle UB read request for column idx
// WAIT   | waiting for the UB response for column idx
// COMMIT | all columns staged; waiting for the systolic array to go quiet
module bias_feeder #(
  parameter int NUM_COLS = 4,
  parameter int ADDR_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     ub_rd_en,
  output logic [ADDR_W-1:0]        ub_rd_addr,
  input  logic [15:0]              ub_rd_data,
  input  logic                     ub_rd_valid,
  input  logic                     sys_valid_any,
  output logic [NUM_COLS*16-1:0]   bias_scalar_out,
  output logic [NUM_COLS-1:0]      bias_load_en,
  output logic                     load_new_bias,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [NUM_COLS-1:0][15:0]    stage_q, stage_d;
  logic                         rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
  logic [NUM_COLS-1:0]          load_en_q, load_en_d;
  logic                         lnb_q, lnb_d;
  logic                         done_q, done_d;
  logic                         busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      stage_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      load_en_q <= '0;
      lnb_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      stage_q   <= stage_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      load_en_q <= load_en_d;
      lnb_q     <= lnb_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are registered from the next state, so a request is on the bus
  // exactly while the FSM sits in REQ and the commit pulse lines up with IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    stage_d   = stage_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    load_en_d = '0;
    lnb_d     = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          idx_d     = '0;
          state_d   = REQ;
          rd_en_d   = 1'b1;
          rd_addr_d = base_addr;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ub_rd_valid) begin
          stage_d[idx_q] = ub_rd_data;
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            addr_d    = addr_q + ADDR_W'(1);
            state_d   = REQ;
            rd_en_d   = 1'b1;
            rd_addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      COMMIT: begin
        if (!sys_valid_any) begin
          load_en_d = '1;
          lnb_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign ub_rd_en        = rd_en_q;
  assign ub_rd_addr      = rd_addr_q;
  assign bias_scalar_out = stage_q;
  assign bias_load_en    = load_en_q;
  assign load_new_bias   = lnb_q;
  assign done            = done_q;
  assign busy            = busy_q;

endmodule
